imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DWIDTH, default 8, is the width of one stream byte.
REQ-002 Parameter IWIDTH, default 16, is the width of one instruction word.
REQ-003 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, is asynchronous and active-high; the one clock is clk.
REQ-005 Port s_valid, input, 1, means a stream byte is presented.
REQ-006 Port s_data, input, DWIDTH, carries the stream byte.
REQ-007 Port s_last, input, 1, qualified by s_valid, marks the final byte of the program.
REQ-008 Port s_ready, output, 1, means the loader accepts a byte this cycle.
REQ-009 Port a, input, 6, is the CPU fetch address (word index 0..63).
REQ-010 Port rd, output, IWIDTH, is the instruction at a.
REQ-011 Port load_done, output, 1, means the program is fully loaded.
REQ-012 Port cpu_hold, output, 1, holds the CPU in reset while loading.
REQ-013 Port word_count, output, 7, is the number of words written (0..64).
REQ-014 Port err_odd, output, 1, flags a program that ended on a high byte.
REQ-015 Port err_ovf, output, 1, flags a 64-word program with no s_last on its final byte.

Function
REQ-016 The loader SHALL own a 64 x IWIDTH instruction store with one synchronous write port and one combinational read port.
REQ-017 rd SHALL equal store[a] combinationally in every state, including during CLEAR and loading.
REQ-018 The FSM SHALL have states CLEAR, LOAD_HI, LOAD_LO, DONE.
REQ-019 CLEAR: s_ready=0; write zero to store[clr_addr], clr_addr counts 0..63, one word per cycle; after writing address 63 -> LOAD_HI (exactly 64 cycles).
REQ-020 Byte transfer SHALL occur only in a cycle where s_valid and s_ready are both 1; s_data/s_last are ignored otherwise.
REQ-021 LOAD_HI: s_ready=1; on transfer latch s_data as the high byte; if s_last -> set err_odd, go DONE, nothing written; else -> LOAD_LO.
REQ-022 LOAD_LO: s_ready=1; on transfer write {hi_byte, s_data} to store[wr_addr], increment wr_addr and word_count in the same edge.
REQ-023 LOAD_LO transfer with s_last=1 -> DONE.
REQ-024 LOAD_LO transfer at wr_addr=63 with s_last=0 -> set err_ovf, go DONE; no wrap to address 0.
REQ-025 LOAD_LO transfer at wr_addr=63 with s_last=1 -> DONE, err_ovf stays 0.
REQ-026 Otherwise a LOAD_LO transfer -> LOAD_HI; with no transfer the FSM holds its state.
REQ-027 DONE: s_ready=0, load_done=1; the FSM stays in DONE until reset; store contents are frozen.
REQ-028 cpu_hold SHALL equal the inverse of load_done, driven combinationally from state.
REQ-029 Word order is big-endian: the first byte of each pair is bits IWIDTH-1:DWIDTH.
REQ-030 err_odd and err_ovf are sticky until reset and are never both set.

Reset
REQ-031 While reset=1: state=CLEAR, clr_addr=0, wr_addr=0, word_count=0, hi_byte=0, err_odd=0, err_ovf=0, load_done=0, cpu_hold=1, s_ready=0.
REQ-032 Reset asserted mid-load SHALL abort the load and, after release, re-run the full 64-cycle CLEAR before any byte is accepted.
REQ-033 Store contents are not reset asynchronously; they are zeroed only by the CLEAR sweep.

Structure
REQ-034 A shared package imem_pkg SHALL hold DWIDTH, IWIDTH, IMEM_DEPTH=64, IMEM_AW=6 and the loader state enum.
REQ-035 The store SHALL be a sub-module imem_ram (64 x IWIDTH, write enable/address/data, async read address/data); the FSM and counters live in imem_loader.

Verification
REQ-036 Release reset, s_valid held 1 -> s_ready first goes 1 exactly 64 cycles later; all 64 rd reads = 0x0000.
REQ-037 Stream 0x12,0x34,0xAB,0xCD(last) -> store[0]=0x1234, store[1]=0xABCD, word_count=2, load_done=1, cpu_hold=0, errors 0.
REQ-038 Stream 0x12,0x34,0x56(last) -> err_odd=1, load_done=1, word_count=1, store[1]=0x0000.
REQ-039 128 bytes, s_last never set -> err_ovf=1 after byte 128, word_count=64, s_ready=0; byte 129 not accepted; store[0] unchanged.
REQ-040 s_valid toggled every other cycle during a 4-byte load -> same result as REQ-037; no byte lost or duplicated.
REQ-041 Reset asserted after 3 bytes, then stream 0xBE,0xEF(last) -> store[0]=0xBEEF, store[1]=0x0000, word_count=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
`timescale 1ns/1ps
package imem_pkg;
  localparam int DWIDTH     = 8;
  localparam int IWIDTH     = 16;
  localparam int IMEM_DEPTH = 64;
  localparam int IMEM_AW    = 6;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    DONE    = 2'd3
  } load_state_t;
endpackage

// File: rtl/imem_ram.sv
// 64-word instruction store: one synchronous write port, one combinational read port.
`timescale 1ns/1ps
module imem_ram #(
  parameter int WIDTH = imem_pkg::IWIDTH,
  parameter int DEPTH = imem_pkg::IMEM_DEPTH,
  parameter int AW    = imem_pkg::IMEM_AW
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] rd
);
  // No reset on the array: contents are only zeroed by the loader's clear sweep.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];
endmodule

// File: rtl/imem_loader.sv
// Clears the instruction store, then assembles big-endian words from a byte stream
// into it while holding the CPU in reset; releases the CPU once the program is loaded.
`timescale 1ns/1ps
module imem_loader #(
  parameter int DWIDTH = imem_pkg::DWIDTH,
  parameter int IWIDTH = imem_pkg::IWIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_valid,
  input  logic [DWIDTH-1:0]           s_data,
  input  logic                        s_last,
  output logic                        s_ready,
  input  logic [imem_pkg::IMEM_AW-1:0] a,
  output logic [IWIDTH-1:0]           rd,
  output logic                        load_done,
  output logic                        cpu_hold,
  output logic [6:0]                  word_count,
  output logic                        err_odd,
  output logic                        err_ovf
);
  import imem_pkg::*;

  localparam logic [IMEM_AW-1:0] LAST_ADDR = IMEM_AW'(IMEM_DEPTH - 1);

  load_state_t        state;
  logic [IMEM_AW-1:0] clr_addr;
  logic [IMEM_AW-1:0] wr_addr;
  logic [DWIDTH-1:0]  hi_byte;
  logic               xfer;
  logic               ram_we;
  logic [IMEM_AW-1:0] ram_wa;
  logic [IWIDTH-1:0]  ram_wd;

  assign xfer     = s_valid && s_ready;
  assign cpu_hold = (state != DONE);

  // Write port is shared between the clear sweep and word assembly.
  always_comb begin
    ram_we = 1'b0;
    ram_wa = clr_addr;
    ram_wd = '0;
    case (state)
      CLEAR: ram_we = 1'b1;
      LOAD_LO: begin
        if (xfer) begin
          ram_we = 1'b1;
          ram_wa = wr_addr;
          ram_wd = {hi_byte, s_data};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      wr_addr    <= '0;
      word_count <= '0;
      hi_byte    <= '0;
      err_odd    <= 1'b0;
      err_ovf    <= 1'b0;
      load_done  <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state   <= LOAD_HI;
            s_ready <= 1'b1;
          end
        end
        LOAD_HI: begin
          if (xfer) begin
            hi_byte <= s_data;
            if (s_last) begin
              err_odd   <= 1'b1;
              state     <= DONE;
              s_ready   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state <= LOAD_LO;
            end
          end
        end
        LOAD_LO: begin
          if (xfer) begin
            wr_addr    <= wr_addr + 1'b1;
            word_count <= word_count + 7'd1;
            if (s_last || wr_addr == LAST_ADDR) begin
              // A full store without s_last on its final byte is an overflow.
              err_ovf   <= !s_last;
              state     <= DONE;
              s_ready   <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state <= LOAD_HI;
            end
          end
        end
        default: ;
      endcase
    end
  end

  imem_ram #(
    .WIDTH(IWIDTH),
    .DEPTH(IMEM_DEPTH),
    .AW   (IMEM_AW)
  ) u_ram (
    .clk(clk),
    .we (ram_we),
    .wa (ram_wa),
    .wd (ram_wd),
    .ra (a),
    .rd (rd)
  );
endmodule
